// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default widths, reset PC, NOP word and
// the fetch-stage state encoding.
package mips_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;   // sll $0,$0,0

    // REQ: request outstanding at pc; HOLD: word parked while decode stalls;
    // DRAIN: a flushed request is still in flight and its data must be dropped.
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/instr/pc with load, clear and sync reset.
// Clear only drops the valid bit; the stale word stays for debug visibility.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc
);

    // register update: reset > clear > load > hold
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= DATA_W'(NOP_INSTR);
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// feeds the IF/ID register, absorbing stalls, flushes and memory latency.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall_cyc.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              flush,
    output logic              ifid_valid,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall_cyc
`endif
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc_next, addr_next;
    logic [DATA_W-1:0] hold_buf, load_instr;
    logic              hold_we, ifid_load, ifid_clr;
    logic              accept, ack;

    // decode takes a new word unless it is stalled on a valid one
    assign accept = !stall || !ifid_valid;
    // req is registered and low right after reset, so a stray ack is ignored
    assign ack    = imem_ack && imem_req;

    // next-state, PC/address and IF/ID control
    always_comb begin
        state_next = state;
        pc_next    = pc;
        addr_next  = imem_addr;
        hold_we    = 1'b0;
        ifid_load  = 1'b0;
        ifid_clr   = 1'b0;
        load_instr = imem_rdata;
        unique case (state)
            REQ: begin
                if (flush) begin
                    ifid_clr = 1'b1;
                    pc_next  = next_pc;
                    // an unacked request must be drained before redirecting
                    if (ack || !imem_req) addr_next  = next_pc;
                    else                  state_next = DRAIN;
                end else if (ack) begin
                    if (accept) begin
                        ifid_load = 1'b1;
                        pc_next   = next_pc;
                        addr_next = next_pc;
                    end else begin
                        hold_we    = 1'b1;
                        state_next = HOLD;
                    end
                end else if (accept) begin
                    ifid_clr = 1'b1;   // word consumed, nothing new: bubble
                end
            end
            HOLD: begin
                load_instr = hold_buf;
                if (flush) begin
                    ifid_clr   = 1'b1;
                    pc_next    = next_pc;
                    addr_next  = next_pc;
                    state_next = REQ;
                end else if (accept) begin
                    ifid_load  = 1'b1;
                    pc_next    = next_pc;
                    addr_next  = next_pc;
                    state_next = REQ;
                end
            end
            DRAIN: begin
                if (flush) begin
                    ifid_clr = 1'b1;
                    pc_next  = next_pc;
                end else if (accept) begin
                    ifid_clr = 1'b1;
                end
                if (ack) begin
                    addr_next  = flush ? next_pc : pc;
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // state, PC and request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REQ;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            imem_req  <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            imem_addr <= addr_next;
            imem_req  <= (state_next != HOLD);
        end
    end

    // parking slot for a word that arrived while decode was stalled
    always_ff @(posedge clk) begin
        if (reset)        hold_buf <= DATA_W'(NOP_INSTR);
        else if (hold_we) hold_buf <= imem_rdata;
    end

    if_id_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ifid (
        .clk        (clk),
        .reset      (reset),
        .load       (ifid_load),
        .clear      (ifid_clr),
        .load_instr (load_instr),
        .load_pc    (pc),
        .valid      (ifid_valid),
        .instr      (ifid_instr),
        .pc         (ifid_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    // free-running performance counters, wrap at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (ifid_load)           perf_fetched   <= perf_fetched + 32'd1;
            if (stall && ifid_valid) perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scripted scenarios with literal expectations, then
// randomized stall/flush/ack/reset traffic checked every cycle against a
// queue-based behavioural model. Honors FETCH_PERF_CNT_EN.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] next_pc = 32'h0;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall_cyc;
`endif

    int checks = 0;
    int errors = 0;
    int mode = 0;   // 0 ack tied 1, 1 no ack, 2 three wait states, 3 random
    int wcnt = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .flush      (flush),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_addr, m_i, m_p;
    bit          m_req, m_v, m_drain, m_init;
    logic [31:0] hq[$];           // word waiting for a stalled decode
    logic [31:0] m_fetched, m_stallc;

    always @(posedge clk) begin
        bit ack, acc;
        ack = imem_ack && m_req;
        acc = !stall || !m_v;
        if (reset) begin
            m_init = 1; m_pc = 32'h0040_0000; m_addr = 32'h0040_0000;
            m_req = 0; m_v = 0; m_i = 0; m_p = 0; m_drain = 0;
            hq.delete(); m_fetched = 0; m_stallc = 0;
        end else if (m_init) begin
            if (stall && m_v) m_stallc++;
            if (hq.size() != 0) begin
                if (flush) begin
                    void'(hq.pop_front()); m_v = 0; m_pc = next_pc; m_addr = next_pc;
                end else if (acc) begin
                    m_v = 1; m_i = hq.pop_front(); m_p = m_pc; m_fetched++;
                    m_pc = next_pc; m_addr = next_pc;
                end
            end else if (m_drain) begin
                if (flush) begin m_pc = next_pc; m_v = 0; end
                else if (acc) m_v = 0;
                if (ack) begin m_drain = 0; m_addr = m_pc; end
            end else if (flush) begin
                m_v = 0;
                if (ack || !m_req) m_addr = next_pc; else m_drain = 1;
                m_pc = next_pc;
            end else if (ack) begin
                if (acc) begin
                    m_v = 1; m_i = imem_rdata; m_p = m_pc; m_fetched++;
                    m_pc = next_pc; m_addr = next_pc;
                end else hq.push_back(imem_rdata);
            end else if (acc) m_v = 0;
            m_req = (hq.size() == 0);
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_init) begin
            chk("pc", pc, m_pc);
            chk("imem_req", 32'(imem_req), 32'(m_req));
            chk("imem_addr", imem_addr, m_addr);
            chk("ifid_valid", 32'(ifid_valid), 32'(m_v));
            chk("ifid_instr", ifid_instr, m_i);
            chk("ifid_pc", ifid_pc, m_p);
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_stall_cyc", perf_stall_cyc, m_stallc);
`endif
        end
    end

    // apply one cycle of stimulus (memory answers from the current address)
    task automatic cyc(input bit r, input bit s, input bit f, input logic [31:0] tgt);
        reset = r; stall = s; flush = f;
        next_pc = f ? tgt : pc + 32'd4;
        case (mode)
            0: imem_ack = 1'b1;
            1: imem_ack = 1'b0;
            2: begin
                imem_ack = imem_req && (wcnt == 3);
                if (imem_req) wcnt = (wcnt == 3) ? 0 : wcnt + 1;
                else          wcnt = 0;
            end
            default: imem_ack = 1'($urandom_range(0, 1));
        endcase
        imem_rdata = mem(imem_addr);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        cyc(0, 0, 0, 0);
        chk("zw_req", 32'(imem_req), 32'd1);
        chk("zw_addr0", imem_addr, 32'h0040_0000);
        cyc(0, 0, 0, 0);
        chk("zw_valid", 32'(ifid_valid), 32'd1);
        chk("zw_instr0", ifid_instr, 32'h1234_5638);
        chk("zw_addr1", imem_addr, 32'h0040_0004);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("st_pre_pc", ifid_pc, 32'h0040_0008);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("st_hold_req", 32'(imem_req), 32'd0);
            chk("st_hold_pc", ifid_pc, 32'h0040_0008);
        end
        cyc(0, 0, 0, 0);
        chk("st_rel_pc", ifid_pc, 32'h0040_000C);
        chk("st_rel_instr", ifid_instr, mem(32'h0040_000C));
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched10", perf_fetched, 32'd10);
        chk("perf_stall3", perf_stall_cyc, 32'd3);
`endif
        mode = 1;
        cyc(0, 0, 1, 32'h0040_0100);
        chk("fl_valid", 32'(ifid_valid), 32'd0);
        chk("fl_drain_addr", imem_addr, 32'h0040_0028);
        mode = 0;
        cyc(0, 0, 0, 0);
        chk("fl_new_addr", imem_addr, 32'h0040_0100);
        chk("fl_discard", 32'(ifid_valid), 32'd0);
        cyc(0, 0, 0, 0);
        chk("fl_tgt_pc", ifid_pc, 32'h0040_0100);
        cyc(0, 0, 1, 32'h0040_0200);
        chk("fa_valid", 32'(ifid_valid), 32'd0);
        chk("fa_addr", imem_addr, 32'h0040_0200);
        cyc(0, 0, 0, 0);
        chk("fa_tgt_pc", ifid_pc, 32'h0040_0200);
        mode = 2; wcnt = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("ws_req", 32'(imem_req), 32'd1);
            chk("ws_addr", imem_addr, 32'h0040_0204);
            chk("ws_valid", 32'(ifid_valid), 32'd0);
        end
        cyc(0, 0, 0, 0);
        chk("ws_load_pc", ifid_pc, 32'h0040_0204);
        chk("ws_next_addr", imem_addr, 32'h0040_0208);
        mode = 1;
        cyc(0, 0, 1, 32'h0040_0300);
        chk("dr_pc", pc, 32'h0040_0300);
        cyc(1, 0, 0, 0);
        chk("rd_pc", pc, 32'h0040_0000);
        chk("rd_addr", imem_addr, 32'h0040_0000);
        chk("rd_req", 32'(imem_req), 32'd0);
        chk("rd_valid", 32'(ifid_valid), 32'd0);
        chk("rd_instr", ifid_instr, 32'd0);
        chk("rd_ifpc", ifid_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rd_perf", perf_fetched | perf_stall_cyc, 32'd0);
`endif
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            mode = (i < 2000) ? 3 : 2;
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 9) == 0), $urandom & 32'hFFFF_FFFC);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
